agu_hash_multi: RTL and testbench
=================================

# agu_hash_multi

Parametrised address-generation unit for the hash (SHAKE) output buffer. It produces word addresses and sub-word lane indices for the sampling datapaths: S/S'/E' in linear mode, E in lane mode, and optional strided access. Compared with the fixed 11-bit generator it replaces, it adds configurable widths and per-level loop limits, a pass counter, a wrap strobe and start/busy/done handshaking. It sits between the top-level controller FSM and the hash RAM address port.

## Interface
- `ADDR_W`, 11: address width.
- `SUB_W`, 3: lane-index width; lanes per word = 2^SUB_W.
- `PASS_W`, 4: pass-counter width.
- `LOOP_L1`, 1343: last address, level 1.
- `LOOP_L2`, 975: last address, level 2.
- `LOOP_L3`, 639: last address, level 3.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `addr_clr` in 1: clear addr, bias, pass_cnt, done, busy.
- `start` in 1: begin a run; loads addr=0, bias=0, pass_cnt=0, busy=1.
- `add_en` in 1: step request; ignored unless busy.
- `mode` in 2: 00 linear, 01 lane, 10 strided, 11 hold.
- `level` in 2: selects loop limit; 00 → limit 0.
- `stride` in ADDR_W: strided-mode increment; 0 ≤ stride ≤ limit+1.
- `pass_limit` in PASS_W: number of full passes before done.
- `addr_output` out ADDR_W: current word address.
- `bias` out SUB_W: current lane index.
- `pass_cnt` out PASS_W: completed passes.
- `wrap` out 1: one-cycle pulse, address wrapped on this step.
- `busy` out 1: run active.
- `done` out 1: sticky completion flag.

## Operation
- Priority, evaluated each rising edge: `rst` > `addr_clr` > `start` > step (`add_en & busy`).
- `rst` and `addr_clr` clear every output to 0.
- `limit` is decoded combinationally from `level`.
- Linear (00):
  - If addr == limit: addr←0, wrap=1, pass_cnt+1.
  - Otherwise addr+1.
  - bias is held.
- Lane (01):
  - If bias == 2^SUB_W−1: bias←0, then apply the linear step rule to addr (including wrap and pass_cnt).
  - Otherwise bias+1 with addr held.
- Strided (10):
  - Compute in ADDR_W+1 bits: n = addr + stride.
  - If n > limit: addr←n−(limit+1), wrap=1, pass_cnt+1.
  - Otherwise addr←n.
  - stride=0 holds addr and never wraps.
  - bias is held.
- Hold (11): no state change, wrap=0.
- Completion: on a step that wraps with pass_cnt+1 == pass_limit:
  - done←1 and busy←0.
  - addr/bias still update to their wrapped values.
- pass_limit=0: done is never asserted by wrapping; the run continues until clr.
- pass_cnt saturates at all-ones and does not roll over.
- `mode` or `level` changes mid-run take effect on the next step. bias and addr are not cleared. If addr > new limit, the next linear or lane step wraps to 0.
- level 00: every addr step is a wrap.
- `add_en` while not busy: no effect.
- `start` while busy: restarts the run and clears done.

## Timing
- All outputs are registered; an update is visible one cycle after the qualifying edge.
- `wrap` is high for exactly the cycle following a wrapping step; otherwise 0.
- `done` rises in the same cycle that `busy` falls. It stays high until `start`, `addr_clr` or `rst`.
- Back-to-back `add_en` gives one step per cycle with no bubbles.
- Reset mid-run: next cycle all outputs are 0 and busy=0.
- Critical path: (ADDR_W+1)-bit add, then compare, then subtract in strided mode.

## Configuration
- `AGU_HASH_STRIDE_EN`
  - Defined: strided mode 10 is implemented and `stride` is used.
  - Undefined: mode 10 behaves as hold (11), the `stride` port remains but is ignored, and no adder/subtractor is synthesised for it.

## Test plan
- Linear, level 11, pass_limit=2: start plus 1280 add_en.
  - wrap pulses after steps 640 and 1280.
  - done=1 and busy=0 after step 1280, with addr=0 and pass_cnt=2.
- Lane, level 11, SUB_W=3, pass_limit=1:
  - 8 steps → addr=1, bias=0.
  - 5120 steps → done with addr=0.
- Strided (macro on), level 10, stride=300, from addr 900: next addr=224 with wrap=1. With the macro off: addr stays 900.
- Priority: rst, addr_clr, start and add_en asserted together → all outputs 0. Then addr_clr together with start → outputs 0, busy=0.
- add_en with busy=0 → no change.
- Level switch 01→11 at addr=1000 in linear mode → next step addr=0, wrap=1.

Source files
------------

// File: rtl/agu_hash_multi.sv
// Address generator for the hash output buffer: linear, lane and (with AGU_HASH_STRIDE_EN) strided modes,
// with per-level loop limits, a saturating pass counter, a wrap strobe and start/busy/done handshaking.
module agu_hash_multi #(
    parameter int ADDR_W  = 11,
    parameter int SUB_W   = 3,
    parameter int PASS_W  = 4,
    parameter int LOOP_L1 = 1343,
    parameter int LOOP_L2 = 975,
    parameter int LOOP_L3 = 639
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_clr,
    input  logic              start,
    input  logic              add_en,
    input  logic [1:0]        mode,
    input  logic [1:0]        level,
    input  logic [ADDR_W-1:0] stride,
    input  logic [PASS_W-1:0] pass_limit,
    output logic [ADDR_W-1:0] addr_output,
    output logic [SUB_W-1:0]  bias,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              wrap,
    output logic              busy,
    output logic              done
);
    logic [ADDR_W-1:0] r_addr;
    logic [SUB_W-1:0]  r_bias;
    logic [PASS_W-1:0] r_pass_cnt;
    logic              r_wrap, r_busy, r_done;

    logic [ADDR_W-1:0] w_limit, w_lin_addr, w_addr_nxt;
    logic [SUB_W-1:0]  w_bias_nxt;
    logic [PASS_W-1:0] w_pass_inc;
    logic              w_lin_wrap, w_wrap, w_finish;

    always_comb begin
        case (level)
            2'b01:   w_limit = ADDR_W'(LOOP_L1);
            2'b10:   w_limit = ADDR_W'(LOOP_L2);
            2'b11:   w_limit = ADDR_W'(LOOP_L3);
            default: w_limit = '0;
        endcase
    end

    // '>=' so an address left above a freshly lowered limit wraps on the next step
    assign w_lin_wrap = (r_addr >= w_limit);
    assign w_lin_addr = w_lin_wrap ? '0 : r_addr + ADDR_W'(1);

`ifdef AGU_HASH_STRIDE_EN
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_sub;
    logic              w_str_wrap;
    assign w_sum      = {1'b0, r_addr} + {1'b0, stride};
    assign w_sub      = w_sum[ADDR_W-1:0] - w_limit - ADDR_W'(1);
    assign w_str_wrap = (stride != '0) && (w_sum > {1'b0, w_limit});
`else
    logic w_unused_stride;
    assign w_unused_stride = ^stride;
`endif

    always_comb begin
        w_addr_nxt = r_addr;
        w_bias_nxt = r_bias;
        w_wrap     = 1'b0;
        case (mode)
            2'b00: begin
                w_addr_nxt = w_lin_addr;
                w_wrap     = w_lin_wrap;
            end
            2'b01: begin
                if (r_bias == '1) begin
                    w_bias_nxt = '0;
                    w_addr_nxt = w_lin_addr;
                    w_wrap     = w_lin_wrap;
                end else begin
                    w_bias_nxt = r_bias + SUB_W'(1);
                end
            end
`ifdef AGU_HASH_STRIDE_EN
            2'b10: begin
                if (stride != '0) begin
                    w_addr_nxt = w_str_wrap ? w_sub : w_sum[ADDR_W-1:0];
                    w_wrap     = w_str_wrap;
                end
            end
`endif
            default: ;
        endcase
    end

    assign w_pass_inc = r_pass_cnt + PASS_W'(1);
    assign w_finish   = w_wrap && (pass_limit != '0) && (w_pass_inc == pass_limit);

    always_ff @(posedge clk) begin
        if (rst || addr_clr) begin
            r_addr     <= '0;
            r_bias     <= '0;
            r_pass_cnt <= '0;
            r_wrap     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (start) begin
            r_addr     <= '0;
            r_bias     <= '0;
            r_pass_cnt <= '0;
            r_wrap     <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (add_en && r_busy) begin
                r_addr <= w_addr_nxt;
                r_bias <= w_bias_nxt;
                r_wrap <= w_wrap;
                if (w_wrap && (r_pass_cnt != '1))
                    r_pass_cnt <= w_pass_inc;
                if (w_finish) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign addr_output = r_addr;
    assign bias        = r_bias;
    assign pass_cnt    = r_pass_cnt;
    assign wrap        = r_wrap;
    assign busy        = r_busy;
    assign done        = r_done;
endmodule

// File: tb/tb_agu_hash_multi.sv
// Scoreboard bench for agu_hash_multi: every cycle's expected outputs come from a behavioural model,
// plus directed checks on the key scenarios. Honours AGU_HASH_STRIDE_EN the same way as the design.
module tb_agu_hash_multi;
    logic        clk = 1'b0;
    logic        rst, addr_clr, start, add_en;
    logic [1:0]  mode, level;
    logic [10:0] stride;
    logic [3:0]  pass_limit;
    logic [10:0] addr_output;
    logic [2:0]  bias;
    logic [3:0]  pass_cnt;
    logic        wrap, busy, done;

    agu_hash_multi dut (
        .clk(clk), .rst(rst), .addr_clr(addr_clr), .start(start), .add_en(add_en),
        .mode(mode), .level(level), .stride(stride), .pass_limit(pass_limit),
        .addr_output(addr_output), .bias(bias), .pass_cnt(pass_cnt),
        .wrap(wrap), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] a;
        logic [2:0]  b;
        logic [3:0]  p;
        logic        w;
        logic        bz;
        logic        d;
    } obs_t;

    obs_t sbq[$];
    int checks = 0, failures = 0;
    int m_addr = 0, m_bias = 0, m_pc = 0, m_wrap = 0, m_busy = 0, m_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Behavioural next-state model; pushes the outputs expected after the coming edge
    task automatic model(input bit r, c, s, e, input logic [1:0] md, lv, input int sd, pl);
        int lim, n;
        bit w, do_lin;
        lim = (lv == 0) ? 0 : (lv == 1) ? 1343 : (lv == 2) ? 975 : 639;
        if (r || c) begin
            m_addr = 0; m_bias = 0; m_pc = 0; m_wrap = 0; m_busy = 0; m_done = 0;
        end else if (s) begin
            m_addr = 0; m_bias = 0; m_pc = 0; m_wrap = 0; m_busy = 1; m_done = 0;
        end else begin
            m_wrap = 0;
            if (e && m_busy != 0) begin
                w = 0;
                do_lin = (md == 0) || (md == 1 && m_bias == 7);
                if (md == 1) m_bias = (m_bias + 1) % 8;
                if (do_lin) begin
                    if (m_addr >= lim) begin m_addr = 0; w = 1; end
                    else m_addr = m_addr + 1;
                end
`ifdef AGU_HASH_STRIDE_EN
                if (md == 2 && sd != 0) begin
                    n = m_addr + sd;
                    if (n > lim) begin m_addr = n - lim - 1; w = 1; end
                    else m_addr = n;
                end
`endif
                if (w) begin
                    m_wrap = 1;
                    if (pl != 0 && m_pc + 1 == pl) begin m_done = 1; m_busy = 0; end
                    if (m_pc < 15) m_pc = m_pc + 1;
                end
            end
        end
        sbq.push_back({11'(m_addr), 3'(m_bias), 4'(m_pc), m_wrap[0], m_busy[0], m_done[0]});
    endtask

    task automatic step(input bit r, c, s, e, input logic [1:0] md, lv,
                        input logic [10:0] sd, input logic [3:0] pl);
        obs_t exp;
        rst = r; addr_clr = c; start = s; add_en = e;
        mode = md; level = lv; stride = sd; pass_limit = pl;
        model(r, c, s, e, md, lv, int'(sd), int'(pl));
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        check("scoreboard", {11'b0, addr_output, bias, pass_cnt, wrap, busy, done}, {11'b0, exp});
    endtask

    initial begin
        int nw, w1, w2;
        rst = 1'b1; addr_clr = 1'b0; start = 1'b0; add_en = 1'b0;
        mode = 2'b00; level = 2'b00; stride = '0; pass_limit = '0;

        // reset state
        step(1, 0, 0, 0, 2'b00, 2'b00, 11'd0, 4'd0);
        check("reset_zero", {addr_output, bias, pass_cnt, wrap, busy, done}, 0);

        // linear, level 11, two passes
        step(0, 0, 1, 0, 2'b00, 2'b11, 11'd0, 4'd2);
        check("start_busy", {busy, done}, 2'b10);
        nw = 0; w1 = 0; w2 = 0;
        for (int i = 1; i <= 1280; i++) begin
            step(0, 0, 0, 1, 2'b00, 2'b11, 11'd0, 4'd2);
            if (wrap) begin
                if (nw == 0) w1 = i; else w2 = i;
                nw++;
            end
        end
        check("lin_wrap_count", nw, 2);
        check("lin_wrap1_step", w1, 640);
        check("lin_wrap2_step", w2, 1280);
        check("lin_done", {done, busy}, 2'b10);
        check("lin_end_addr", addr_output, 0);
        check("lin_end_pass", pass_cnt, 2);

        // add_en while idle: nothing moves
        step(0, 0, 0, 1, 2'b00, 2'b11, 11'd0, 4'd2);
        check("idle_add_en", {addr_output, pass_cnt, wrap, busy, done}, {11'd0, 4'd2, 3'b001});

        // lane mode, one pass
        step(0, 0, 1, 0, 2'b01, 2'b11, 11'd0, 4'd1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 2'b01, 2'b11, 11'd0, 4'd1);
        check("lane_8_addr", addr_output, 1);
        check("lane_8_bias", bias, 0);
        for (int i = 8; i < 5120; i++) step(0, 0, 0, 1, 2'b01, 2'b11, 11'd0, 4'd1);
        check("lane_done", {done, busy, wrap}, 3'b101);
        check("lane_end_addr", addr_output, 0);

        // strided from addr 900 at level 10
        step(0, 0, 1, 0, 2'b00, 2'b10, 11'd0, 4'd0);
        for (int i = 0; i < 900; i++) step(0, 0, 0, 1, 2'b00, 2'b10, 11'd0, 4'd0);
        check("pre_stride_addr", addr_output, 900);
        step(0, 0, 0, 1, 2'b10, 2'b10, 11'd300, 4'd0);
`ifdef AGU_HASH_STRIDE_EN
        check("stride_addr", addr_output, 224);
        check("stride_wrap", wrap, 1);
`else
        check("stride_off_addr", addr_output, 900);
        check("stride_off_wrap", wrap, 0);
`endif
        step(0, 0, 0, 1, 2'b10, 2'b10, 11'd0, 4'd0);
        step(0, 0, 0, 1, 2'b11, 2'b10, 11'd300, 4'd0);

        // priority: everything at once, then clr with start
        step(1, 1, 1, 1, 2'b00, 2'b11, 11'd0, 4'd0);
        check("prio_all", {addr_output, bias, pass_cnt, wrap, busy, done}, 0);
        step(0, 0, 1, 0, 2'b00, 2'b11, 11'd0, 4'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 2'b00, 2'b11, 11'd0, 4'd0);
        step(0, 1, 1, 0, 2'b00, 2'b11, 11'd0, 4'd0);
        check("prio_clr_start", {addr_output, bias, pass_cnt, wrap, busy, done}, 0);

        // level switch 01 -> 11 above the new limit
        step(0, 0, 1, 0, 2'b00, 2'b01, 11'd0, 4'd0);
        for (int i = 0; i < 1000; i++) step(0, 0, 0, 1, 2'b00, 2'b01, 11'd0, 4'd0);
        check("lvl_pre_addr", addr_output, 1000);
        step(0, 0, 0, 1, 2'b00, 2'b11, 11'd0, 4'd0);
        check("lvl_switch", {addr_output, wrap}, {11'd0, 1'b1});

        // level 00 wraps every step; pass counter saturates
        step(0, 0, 1, 0, 2'b00, 2'b00, 11'd0, 4'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 2'b00, 2'b00, 11'd0, 4'd0);
        check("pass_saturate", pass_cnt, 15);
        check("lvl0_busy", {busy, done, wrap}, 3'b101);

        // reset mid-run
        step(1, 0, 0, 1, 2'b00, 2'b00, 11'd0, 4'd0);
        check("rst_midrun", {addr_output, bias, pass_cnt, wrap, busy, done}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
